// File: rtl/dependency_matrix.sv
`default_nettype none
// ============================================================================
// Module      : dependency_matrix
// Description : Scheduler wakeup matrix; one row of producer-tag bits per entry,
//               ready when the entry is allocated and all its bits are clear.
// Revision    : 1.0 - initial release
// ============================================================================
module dependency_matrix #(
  parameter int NUM_ROWS = 8,
  parameter int NUM_COLS = 8
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        w_en,
  input  logic [((NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1)-1:0] w_row_index,
  input  logic [NUM_COLS-1:0]                         set_lines,
  input  logic                                        clear_en,
  input  logic [NUM_COLS-1:0]                         clear_lines,
  input  logic                                        free_en,
  input  logic [((NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1)-1:0] free_row_index,
  output logic [NUM_ROWS-1:0]                         ready_vector
);

  localparam int C_IDX_W = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;

  logic [NUM_ROWS-1:0][NUM_COLS-1:0] dep_q;
  logic [NUM_ROWS-1:0][NUM_COLS-1:0] dep_d;
  logic [NUM_ROWS-1:0]               valid_q;
  logic [NUM_ROWS-1:0]               valid_d;
  logic [NUM_COLS-1:0]               clr_mask;

  assign clr_mask = clear_en ? clear_lines : '0;

  // Clear, then free, then write: the write overrides a same-row free, and the
  // written row is still masked by a concurrent clear so no stale bit survives.
  always_comb begin
    dep_d   = dep_q;
    valid_d = valid_q;
    for (int r = 0; r < NUM_ROWS; r++) begin
      dep_d[r] = dep_q[r] & ~clr_mask;
      if (free_en && (free_row_index == C_IDX_W'(r))) begin
        dep_d[r]   = '0;
        valid_d[r] = 1'b0;
      end
      if (w_en && (w_row_index == C_IDX_W'(r))) begin
        dep_d[r]   = set_lines & ~clr_mask;
        valid_d[r] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dep_q   <= '0;
      valid_q <= '0;
    end else begin
      dep_q   <= dep_d;
      valid_q <= valid_d;
    end
  end

  generate
    for (genvar r = 0; r < NUM_ROWS; r++) begin : g_ready
      assign ready_vector[r] = valid_q[r] & ~|dep_q[r];
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_dependency_matrix.sv
`default_nettype none
// ============================================================================
// Module      : tb_dependency_matrix
// Description : Scoreboard bench for dependency_matrix (8x8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dependency_matrix;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       w_en = 1'b0;
  logic [2:0] w_row_index = '0;
  logic [7:0] set_lines = '0;
  logic       clear_en = 1'b0;
  logic [7:0] clear_lines = '0;
  logic       free_en = 1'b0;
  logic [2:0] free_row_index = '0;
  logic [7:0] ready_vector;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] m_dep [8];
  logic [7:0] m_valid;
  logic [7:0] exp_q [$];
  string      tag_q [$];

  dependency_matrix #(.NUM_ROWS(8), .NUM_COLS(8)) dut (
    .clk            (clk),
    .rst            (rst),
    .w_en           (w_en),
    .w_row_index    (w_row_index),
    .set_lines      (set_lines),
    .clear_en       (clear_en),
    .clear_lines    (clear_lines),
    .free_en        (free_en),
    .free_row_index (free_row_index),
    .ready_vector   (ready_vector)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Reference behaviour for one cycle, applied to the bench's own state copy.
  task automatic model_update();
    if (rst) begin
      for (int r = 0; r < 8; r++) m_dep[r] = '0;
      m_valid = '0;
    end else begin
      for (int r = 0; r < 8; r++)
        if (clear_en) m_dep[r] = m_dep[r] & ~clear_lines;
      if (free_en) begin
        m_dep[free_row_index]   = '0;
        m_valid[free_row_index] = 1'b0;
      end
      if (w_en) begin
        m_dep[w_row_index]   = clear_en ? (set_lines & ~clear_lines) : set_lines;
        m_valid[w_row_index] = 1'b1;
      end
    end
  endtask

  function automatic logic [7:0] model_ready();
    logic [7:0] rv;
    for (int r = 0; r < 8; r++) rv[r] = m_valid[r] && (m_dep[r] == 8'h00);
    return rv;
  endfunction

  // Drive one cycle of inputs, push the expectation, then compare after the edge.
  task automatic op(input string tag, input logic r_in,
                    input logic we, input logic [2:0] wi, input logic [7:0] sl,
                    input logic ce, input logic [7:0] cl,
                    input logic fe, input logic [2:0] fi,
                    input bit has_exp, input logic [7:0] exp);
    rst = r_in; w_en = we; w_row_index = wi; set_lines = sl;
    clear_en = ce; clear_lines = cl; free_en = fe; free_row_index = fi;
    model_update();
    exp_q.push_back(has_exp ? exp : model_ready());
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
    check_eq(tag_q.pop_front(), ready_vector, exp_q.pop_front());
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int r = 0; r < 8; r++) m_dep[r] = '0;
    m_valid = '0;

    op("reset",      1, 0,0,8'h00, 0,8'h00, 0,0, 1, 8'h00);
    for (int i = 0; i < 3; i++)
      op("idle",     0, 0,0,8'h00, 0,8'h00, 0,0, 1, 8'h00);
    op("wr7",        0, 1,7,8'h42, 0,8'h00, 0,0, 1, 8'h00);
    op("wr0_zero",   0, 1,0,8'h00, 0,8'h00, 0,0, 1, 8'h01);
    op("free0",      0, 0,0,8'h00, 0,8'h00, 1,0, 1, 8'h00);
    op("clr_b6",     0, 0,0,8'h00, 1,8'h40, 0,0, 1, 8'h00);
    op("clr_b1",     0, 0,0,8'h00, 1,8'h02, 0,0, 1, 8'h80);
    op("wr_clr_same",0, 1,3,8'h04, 1,8'h04, 0,0, 1, 8'h88);
    op("wr2_c4",     0, 1,2,8'h10, 0,8'h00, 0,0, 1, 8'h88);
    op("wr5_c4",     0, 1,5,8'h10, 0,8'h00, 0,0, 1, 8'h88);
    op("clr_c4_both",0, 0,0,8'h00, 1,8'h10, 0,0, 1, 8'hAC);
    op("wr_free_4",  0, 1,4,8'h01, 0,8'h00, 1,4, 1, 8'hAC);
    op("row4_valid", 0, 0,0,8'h00, 1,8'h01, 0,0, 1, 8'hBC);
    op("rst_mid",    1, 1,6,8'h00, 1,8'hFF, 0,0, 1, 8'h00);
    op("wr1_after",  0, 1,1,8'h00, 0,8'h00, 0,0, 1, 8'h02);
    op("rewrite1",   0, 1,1,8'h80, 0,8'h00, 0,0, 1, 8'h00);
    op("rewrite1_0", 0, 1,1,8'h00, 0,8'h00, 0,0, 1, 8'h02);
    op("free_inval", 0, 0,0,8'h00, 0,8'h00, 1,6, 1, 8'h02);
    op("diag_wr2",   0, 1,2,8'h04, 0,8'h00, 0,0, 1, 8'h02);
    op("diag_clr2",  0, 0,0,8'h00, 1,8'h04, 0,0, 1, 8'h06);
    op("wr6_free1",  0, 1,6,8'h00, 0,8'h00, 1,1, 1, 8'h44);
    op("clr_dis",    0, 1,0,8'h01, 0,8'h01, 0,0, 1, 8'h44);
    op("clr_en",     0, 0,0,8'h00, 1,8'h01, 0,0, 1, 8'h45);
    op("free_clr",   0, 0,0,8'h00, 1,8'hFF, 1,0, 1, 8'h44);

    for (int i = 0; i < 300; i++)
      op("random", ($urandom_range(0, 39) == 0),
         ($urandom_range(0, 2) == 0), 3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)) & 8'($urandom_range(0, 255)),
         ($urandom_range(0, 2) == 0), 8'($urandom_range(0, 255)),
         ($urandom_range(0, 3) == 0), 3'($urandom_range(0, 7)),
         0, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dependency_matrix.md
# dependency_matrix

Wakeup dependency matrix for the out-of-order scheduler. It holds one row per scheduler entry, and each row is a bit-vector of the producer columns that the entry still waits on. Producers broadcast completion by clearing columns. The block reports which allocated entries have no outstanding dependencies on `ready_vector`, which feeds select/issue logic.

## Interface
Parameters:
- `NUM_ROWS`, default 8: number of scheduler entries (rows).
- `NUM_COLS`, default 8: number of producer tags (columns).

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst`, input, 1: reset, synchronous and active-high.
- `w_en`, input, 1: write/allocate a row this cycle.
- `w_row_index`, input, `$clog2(NUM_ROWS)`: row to write.
- `set_lines`, input, `NUM_COLS`: dependency bits loaded into the written row.
- `clear_en`, input, 1: apply a column clear this cycle.
- `clear_lines`, input, `NUM_COLS`: columns to clear in every row.
- `free_en`, input, 1: deallocate a row this cycle.
- `free_row_index`, input, `$clog2(NUM_ROWS)`: row to free.
- `ready_vector`, output, `NUM_ROWS`: bit r = row r valid and has no dependency bits set.

## Operation
State:
- `dep[NUM_ROWS][NUM_COLS]` dependency bits.
- `valid[NUM_ROWS]`: row is allocated.

Reset:
- All `dep` bits and all `valid` bits go to 0, so `ready_vector` = 0.

Write (`w_en`=1):
- `dep[w_row_index]` is overwritten (not OR-ed) with `set_lines`.
- `valid[w_row_index]` is set to 1.

Clear (`clear_en`=1):
- For every row r and every column c with `clear_lines[c]`=1, `dep[r][c]` goes to 0.
- Multiple columns may be cleared at once.
- Rows not being written are unaffected except for the cleared columns.
- `clear_lines` is ignored when `clear_en`=0.

Free (`free_en`=1):
- `dep[free_row_index]` goes to all 0.
- `valid[free_row_index]` goes to 0.

Ready:
- `ready_vector[r] = valid[r] & ~|dep[r]`.
- Purely combinational from registered state; no input-to-output combinational path.

Simultaneous events in one cycle:
- Write and clear: the written row stores `set_lines & ~clear_lines`, so a producer completing in the allocation cycle leaves no stale bit. All other rows are cleared normally.
- Write and free, same index: the write wins; the row is valid with `set_lines`, masked by any concurrent clear.
- Write and free, different indices: both take effect.
- Free and clear: independent; the freed row ends at 0.

Boundary conditions:
- An index ≥ `NUM_ROWS` (possible only when `NUM_ROWS` is not a power of two) makes that write or free a no-op.
- Writing an already-valid row silently replaces it.
- Freeing an invalid row is harmless.
- Diagonal bits (row r, column r) are ordinary bits with no special treatment.

## Timing
- Writes, clears and frees commit at the rising edge where their enable is sampled high.
- `ready_vector` reflects the new state immediately after that edge, so latency from enable to ready change is 1 cycle.
- A row written with `set_lines`=0 becomes ready in the cycle after the write edge.
- A clear that removes the last outstanding bit makes the row ready in the cycle after the clear edge.
- Reset asserted mid-operation overrides every other input that cycle. After the reset edge all state is 0.
- There are no handshakes and no stalls; every operation is accepted every cycle.

## Test plan
1. Reset, then idle: `ready_vector` = 8'h00 after the reset edge and stays 8'h00.
2. Write row 7 with `set_lines`=8'b01000010, then the next cycle write row 0 with 8'b00000000: after the second edge `ready_vector` = 8'h01; row 7 is not ready.
3. Free row 0: `ready_vector` = 8'h00 after the edge.
4. Clear 8'b01000000: row 7 keeps bit 1, `ready_vector` = 8'h00. Then clear 8'b00000010: `ready_vector` = 8'h80.
5. Same cycle: write row 3 with 8'b00000100 and clear 8'b00000100: row 3 is ready next cycle (`ready_vector[3]`=1). Also, with rows 2 and 5 both depending on column 4, a single clear of 8'h10 makes both ready together.
6. Same cycle: write row 4 with 8'h01 and free row 4: row 4 is valid, not ready. Assert `rst` with several rows valid: `ready_vector` = 8'h00 next cycle, and a subsequent write of row 1 with 8'h00 yields 8'h02.
